// File: rtl/chan_est_interp_seq.sv
// Sequential pilot interpolator/extrapolator: streams N = 2^LOG2_N points per
// request, one per cycle, from a per-lane accumulator stepping by (B - A).
module chan_est_interp_seq #(
  parameter int WIDTH  = 17,
  parameter int LOG2_N = 2,
  parameter int CH     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic [CH*WIDTH-1:0]       est_a,
  input  logic [CH*WIDTH-1:0]       est_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH*(WIDTH+2)-1:0]   out_data,
  output logic [LOG2_N-1:0]         out_idx,
  output logic                      out_last
);

  localparam int AW = WIDTH + LOG2_N + 3;
  localparam int DW = WIDTH + 1;
  localparam int OW = WIDTH + 2;
  localparam logic signed [AW-1:0] HALF     = AW'(2 ** (LOG2_N - 1));
  localparam logic [LOG2_N-1:0]    LAST_IDX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_nxt;
  logic signed [AW-1:0]    acc_p0 [CH];
  logic signed [DW-1:0]    dlt_p0 [CH];
  logic signed [AW-1:0]    acc_ld [CH];
  logic signed [DW-1:0]    dlt_ld [CH];
  logic [LOG2_N-1:0]       cnt_p0;
  logic                    vld_p0;
  logic                    accept;
  logic                    adv;

  // Round half toward +inf, then drop the N scaling; result always fits OW bits.
  function automatic logic signed [OW-1:0] round_shift(input logic signed [AW-1:0] a);
    return OW'((a + HALF) >>> LOG2_N);
  endfunction

  function automatic logic signed [AW-1:0] ext_step(input logic signed [DW-1:0] d);
    return {{(AW-DW){d[DW-1]}}, d};
  endfunction

  assign vld_p0   = (state == RUN);
  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_valid;
  assign adv      = vld_p0 && out_ready;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic signed [WIDTH-1:0] a, b, base;
    assign a    = est_a[c*WIDTH +: WIDTH];
    assign b    = est_b[c*WIDTH +: WIDTH];
    assign base = mode ? b : a;
    assign dlt_ld[c] = {b[WIDTH-1], b} - {a[WIDTH-1], a};
    assign acc_ld[c] = {{(AW-WIDTH-LOG2_N){base[WIDTH-1]}}, base, {LOG2_N{1'b0}}};
    assign out_data[c*OW +: OW] = round_shift(acc_p0[c]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (out_ready && (cnt_p0 == LAST_IDX)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: accumulator and point counter, loaded on accept, stepped on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      for (int c = 0; c < CH; c++) begin
        acc_p0[c] <= '0;
        dlt_p0[c] <= '0;
      end
    end else if (accept) begin
      cnt_p0 <= '0;
      for (int c = 0; c < CH; c++) begin
        acc_p0[c] <= acc_ld[c];
        dlt_p0[c] <= dlt_ld[c];
      end
    end else if (adv) begin
      cnt_p0 <= cnt_p0 + LOG2_N'(1);
      for (int c = 0; c < CH; c++)
        acc_p0[c] <= acc_p0[c] + ext_step(dlt_p0[c]);
    end
  end

  assign out_valid = vld_p0;
  assign out_idx   = cnt_p0;
  assign out_last  = (cnt_p0 == LAST_IDX);

endmodule
